// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock through a
// start/done handshake, with a dedicated divide-by-zero result path.
module seq_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    p_q, p_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [2*N:0]  pq_shift;
    logic [N:0]    trial;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        pq_shift = {p_q, q_q} << 1;
        trial    = pq_shift[2*N:N] - {1'b0, dvs_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d = divisor;
                    p_d   = '0;
                    q_d   = dividend;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // A negative trial (borrow into bit N) restores P and shifts in a 0.
                p_d   = trial[N] ? pq_shift[2*N:N] : trial;
                q_d   = pq_shift[N-1:0] | {{(N-1){1'b0}}, ~trial[N]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    quo_d   = q_d;
                    rem_d   = p_d[N-1:0];
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset, latency, boundaries, divide-by-zero,
// handshake rules, an exhaustive N=4 sweep and random N=8 operations.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [3:0] quotient, remainder;

    logic       start8 = 1'b0;
    logic [7:0] dividend8 = '0;
    logic [7:0] divisor8 = '0;
    logic       busy8, done8, div_by_zero8;
    logic [7:0] quotient8, remainder8;

    int total = 0;
    int bad = 0;

    seq_divider #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient),
        .remainder(remainder), .div_by_zero(div_by_zero)
    );

    seq_divider #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8),
        .dividend(dividend8), .divisor(divisor8),
        .busy(busy8), .done(done8), .quotient(quotient8),
        .remainder(remainder8), .div_by_zero(div_by_zero8)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one N=4 request from IDLE; lat counts edges after the accepting edge.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          output logic [3:0] q, output logic [3:0] r, output logic z,
                          output int lat, output logic done_after, output logic timed_out);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start     = 1'b0;
        lat       = 0;
        timed_out = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        if (done !== 1'b1) timed_out = 1'b1;
        q = quotient;
        r = remainder;
        z = div_by_zero;
        step();
        done_after = done;
    endtask

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] q, output logic [7:0] r,
                           output int lat, output logic timed_out);
        dividend8 = a;
        divisor8  = b;
        start8    = 1'b1;
        step();
        start8    = 1'b0;
        lat       = 0;
        timed_out = 1'b0;
        while (done8 !== 1'b1 && lat < 60) begin
            step();
            lat++;
        end
        if (done8 !== 1'b1) timed_out = 1'b1;
        q = quotient8;
        r = remainder8;
        step();
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'b0) begin
            bad++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b q=%0d r=%0d z=%b, expected all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        #3;
        rst_n = 1'b1;
        step();
        step();
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [3:0] q, r;
        logic z, da, to;
        int lat;
        run_op(4'd13, 4'd3, q, r, z, lat, da, to);
        total++;
        if (to !== 1'b0 || q !== 4'd4 || r !== 4'd1 || z !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_13_3: got q=%0d r=%0d z=%b timeout=%b, expected q=4 r=1 z=0", q, r, z, to);
        end
        total++;
        if (lat != 4) begin
            bad++;
            $display("[TB] FAIL basic_latency: got %0d, expected 4", lat);
        end
        total++;
        if (da !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_done_pulse: done after pulse got %b, expected 0", da);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen = 1'b0;
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 11'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_run: got busy=%b done=%b q=%0d r=%0d z=%b, expected all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("[TB] FAIL reset_abandon: got activity after reset release, expected none");
        end
    endtask

    task automatic test_boundaries();
        logic [3:0] vec [5][4] = '{'{4'd15, 4'd1, 4'd15, 4'd0},
                                   '{4'd5, 4'd7, 4'd0, 4'd5},
                                   '{4'd15, 4'd15, 4'd1, 4'd0},
                                   '{4'd0, 4'd9, 4'd0, 4'd0},
                                   '{4'd14, 4'd5, 4'd2, 4'd4}};
        logic [3:0] q, r;
        logic z, da, to;
        int lat;
        for (int i = 0; i < 5; i++) begin
            run_op(vec[i][0], vec[i][1], q, r, z, lat, da, to);
            total++;
            if (to !== 1'b0 || q !== vec[i][2] || r !== vec[i][3] || z !== 1'b0 || lat != 4) begin
                bad++;
                $display("[TB] FAIL boundary_%0d_%0d: got q=%0d r=%0d z=%b lat=%0d, expected q=%0d r=%0d z=0 lat=4",
                         vec[i][0], vec[i][1], q, r, z, lat, vec[i][2], vec[i][3]);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [3:0] q, r;
        logic z, da, to;
        int lat;
        run_op(4'd9, 4'd0, q, r, z, lat, da, to);
        total++;
        if (to !== 1'b0 || q !== 4'd15 || r !== 4'd9 || z !== 1'b1) begin
            bad++;
            $display("[TB] FAIL div_zero: got q=%0d r=%0d z=%b, expected q=15 r=9 z=1", q, r, z);
        end
        total++;
        if (lat != 0 || da !== 1'b0) begin
            bad++;
            $display("[TB] FAIL div_zero_latency: got lat=%0d done_after=%b, expected lat=0 done_after=0", lat, da);
        end
        run_op(4'd8, 4'd2, q, r, z, lat, da, to);
        total++;
        if (to !== 1'b0 || q !== 4'd4 || r !== 4'd0 || z !== 1'b0 || lat != 4) begin
            bad++;
            $display("[TB] FAIL after_zero_8_2: got q=%0d r=%0d z=%b lat=%0d, expected q=4 r=0 z=0 lat=4", q, r, z, lat);
        end
    endtask

    task automatic test_ignore_start();
        int lat = 0;
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        lat = 1;
        dividend = 4'd14;
        divisor  = 4'd4;
        start    = 1'b1;
        step();
        lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        total++;
        if (done !== 1'b1 || quotient !== 4'd4 || remainder !== 4'd1 || lat != 4) begin
            bad++;
            $display("[TB] FAIL ignore_start: got done=%b q=%0d r=%0d lat=%0d, expected done=1 q=4 r=1 lat=4",
                     done, quotient, remainder, lat);
        end
        step();
        step();
        total++;
        if (busy !== 1'b0 || quotient !== 4'd4 || remainder !== 4'd1) begin
            bad++;
            $display("[TB] FAIL ignore_not_queued: got busy=%b q=%0d r=%0d, expected busy=0 q=4 r=1",
                     busy, quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        step();
        dividend = 4'd14;
        divisor  = 4'd4;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        total++;
        if (done !== 1'b1 || quotient !== 4'd4 || remainder !== 4'd1) begin
            bad++;
            $display("[TB] FAIL b2b_first: got done=%b q=%0d r=%0d, expected done=1 q=4 r=1", done, quotient, remainder);
        end
        step();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_idle: got busy=%b, expected 0", busy);
        end
        step();
        start = 1'b0;
        lat = 0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_accept: got busy=%b, expected 1", busy);
        end
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        total++;
        if (done !== 1'b1 || quotient !== 4'd3 || remainder !== 4'd2 || lat != 4) begin
            bad++;
            $display("[TB] FAIL b2b_second: got done=%b q=%0d r=%0d lat=%0d, expected done=1 q=3 r=2 lat=4",
                     done, quotient, remainder, lat);
        end
        step();
    endtask

    task automatic test_sweep_n4();
        logic [3:0] q, r;
        logic z, da, to;
        int lat;
        bit ok;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(4'(a), 4'(b), q, r, z, lat, da, to);
                if (b == 0)
                    ok = (to === 1'b0) && (q === 4'd15) && (int'(r) == a) && (z === 1'b1) && (lat == 0);
                else
                    ok = (to === 1'b0) && (int'(q) * b + int'(r) == a) && (int'(r) < b) && (z === 1'b0) && (lat == 4);
                total++;
                if (!ok) begin
                    bad++;
                    $display("[TB] FAIL sweep_%0d_%0d: got q=%0d r=%0d z=%b lat=%0d, expected q=%0d r=%0d",
                             a, b, q, r, z, lat, (b == 0) ? 15 : a / b, (b == 0) ? a : a % b);
                end
            end
        end
    endtask

    task automatic test_random_n8();
        logic [7:0] q, r;
        logic to;
        int lat, a, b;
        for (int i = 0; i < 30; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(1, 255));
            run_op8(8'(a), 8'(b), q, r, lat, to);
            total++;
            if (to !== 1'b0 || int'(q) * b + int'(r) != a || int'(r) >= b || int'(q) != a / b || lat != 8) begin
                bad++;
                $display("[TB] FAIL rand8_%0d_%0d: got q=%0d r=%0d lat=%0d, expected q=%0d r=%0d lat=8",
                         a, b, q, r, lat, a / b, a % b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_mid_run();
        test_boundaries();
        test_div_by_zero();
        test_ignore_start();
        test_back_to_back();
        test_sweep_n4();
        test_random_n8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
